// File: rtl/dma_pkg.sv
// Shared definitions for the DMA bus requester.
//   - state_t : requester FSM states
//   - ADDR_W / DATA_W / CNT_W : default address, data and count widths
package dma_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/dma_bus_requester.sv
// DMA-side bus master. It requests the shared data bus, then copies a block
// of words from src to dst one word at a time (read, then write) through a
// one-word buffer. If the grant drops, it yields at once and resumes at the
// interrupted access; a buffered word is written without being re-read.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin a transfer (sampled only in IDLE)
//   src_addr, dst_addr   first source / destination address
//   count                number of words to move
//   bus_req, bus_grant   request to / grant from the bus controller
//   mem_addr, mem_rd, mem_wr, mem_wdata, mem_rdata, mem_ready
//                        memory port; an access completes on mem_ready
//   busy                 transfer in progress (REQ/RD/WR)
//   done                 one-cycle completion pulse
//   remaining            words still to move
module dma_bus_requester #(
  parameter int ADDR_W = dma_pkg::ADDR_W,
  parameter int DATA_W = dma_pkg::DATA_W,
  parameter int CNT_W  = dma_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  remaining
);
  import dma_pkg::*;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] src_reg, src_next;
  logic [ADDR_W-1:0] dst_reg, dst_next;
  logic [CNT_W-1:0]  rem_reg, rem_next;
  logic [DATA_W-1:0] buf_reg, buf_next;
  // Set once a word sits in the buffer but has not been written yet, so a
  // re-grant goes straight back to WR.
  logic              resume_wr_reg, resume_wr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      rem_reg       <= '0;
      buf_reg       <= '0;
      resume_wr_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      src_reg       <= src_next;
      dst_reg       <= dst_next;
      rem_reg       <= rem_next;
      buf_reg       <= buf_next;
      resume_wr_reg <= resume_wr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    src_next       = src_reg;
    dst_next       = dst_reg;
    rem_next       = rem_reg;
    buf_next       = buf_reg;
    resume_wr_next = resume_wr_reg;
    bus_req        = 1'b0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    busy           = 1'b0;
    done           = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            src_next       = src_addr;
            dst_next       = dst_addr;
            rem_next       = count;
            resume_wr_next = 1'b0;
            state_next     = REQ;
          end else begin
            // Empty block: report completion without touching the bus.
            state_next = FIN;
          end
        end
      end

      REQ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (bus_grant) state_next = resume_wr_reg ? WR : RD;
      end

      RD: begin
        bus_req  = 1'b1;
        busy     = 1'b1;
        mem_rd   = bus_grant;
        mem_addr = src_reg;
        // Losing the grant wins over a simultaneous mem_ready.
        if (!bus_grant) begin
          state_next = REQ;
        end else if (mem_ready) begin
          buf_next       = mem_rdata;
          resume_wr_next = 1'b1;
          state_next     = WR;
        end
      end

      WR: begin
        bus_req   = 1'b1;
        busy      = 1'b1;
        mem_wr    = bus_grant;
        mem_addr  = dst_reg;
        mem_wdata = buf_reg;
        if (!bus_grant) begin
          state_next = REQ;
        end else if (mem_ready) begin
          src_next       = src_reg + 1'b1;
          dst_next       = dst_reg + 1'b1;
          rem_next       = rem_reg - 1'b1;
          resume_wr_next = 1'b0;
          state_next     = (rem_reg == CNT_W'(1)) ? FIN : RD;
        end
      end

      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign remaining = rem_reg;

endmodule

// File: tb/tb_dma_bus_requester.sv
module tb_dma_bus_requester;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] src_addr, dst_addr, count;
  logic       bus_req, bus_grant;
  logic [7:0] mem_addr;
  logic       mem_rd, mem_wr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       mem_ready;
  logic       busy, done;
  logic [7:0] remaining;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dma_bus_requester dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
    .bus_req(bus_req), .bus_grant(bus_grant),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .remaining(remaining)
  );

  // Zero-wait memory model: combinational read, write on a completed access.
  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h55;
      mem[8'h10] <= 8'hA1; mem[8'h11] <= 8'hB2; mem[8'h12] <= 8'hC3;
      mem[8'hFF] <= 8'h5A; mem[8'h00] <= 8'h6B; mem[8'h01] <= 8'h7C;
    end else if (mem_wr && mem_ready) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  typedef struct packed {
    logic       req, rd, wr;
    logic [7:0] addr, wdata;
    logic       dn, bz;
    logic [7:0] rem;
  } exp_t;

  typedef struct {
    logic       st;
    logic [7:0] src, dst, cnt;
    logic       g, r;
    exp_t       exp;
  } vec_t;

  vec_t vq[$];

  task automatic row(input logic st, input logic [7:0] s, input logic [7:0] d,
                     input logic [7:0] c, input logic g, input logic r,
                     input logic req, input logic rd, input logic wr,
                     input logic [7:0] a, input logic [7:0] wd,
                     input logic dn, input logic bz, input logic [7:0] rm);
    vec_t v;
    v.st = st; v.src = s; v.dst = d; v.cnt = c; v.g = g; v.r = r;
    v.exp = '{req: req, rd: rd, wr: wr, addr: a, wdata: wd, dn: dn, bz: bz, rem: rm};
    vq.push_back(v);
  endtask

  function automatic exp_t actual();
    return '{req: bus_req, rd: mem_rd, wr: mem_wr, addr: mem_addr,
             wdata: mem_wdata, dn: done, bz: busy, rem: remaining};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  initial begin
    // Table: inputs {start,src,dst,count,grant,ready} -> outputs
    // {bus_req,mem_rd,mem_wr,mem_addr,mem_wdata,done,busy,remaining}.
    // Basic 3-word copy: done in cycle 8 counting the start cycle as 0.
    row(1, 8'h10, 8'h80, 8'd3, 1, 1,  0,0,0, 8'h00, 8'h00, 0,0, 8'd0);
    row(0, 8'h10, 8'h80, 8'd3, 1, 1,  1,0,0, 8'h00, 8'h00, 0,1, 8'd3);
    row(0, 8'h10, 8'h80, 8'd3, 1, 1,  1,1,0, 8'h10, 8'h00, 0,1, 8'd3);
    row(0, 8'h10, 8'h80, 8'd3, 1, 1,  1,0,1, 8'h80, 8'hA1, 0,1, 8'd3);
    row(0, 8'h10, 8'h80, 8'd3, 1, 1,  1,1,0, 8'h11, 8'h00, 0,1, 8'd2);
    row(0, 8'h10, 8'h80, 8'd3, 1, 1,  1,0,1, 8'h81, 8'hB2, 0,1, 8'd2);
    row(0, 8'h10, 8'h80, 8'd3, 1, 1,  1,1,0, 8'h12, 8'h00, 0,1, 8'd1);
    row(0, 8'h10, 8'h80, 8'd3, 1, 1,  1,0,1, 8'h82, 8'hC3, 0,1, 8'd1);
    row(0, 8'h10, 8'h80, 8'd3, 1, 1,  0,0,0, 8'h00, 8'h00, 1,0, 8'd0);
    row(0, 8'h10, 8'h80, 8'd3, 1, 1,  0,0,0, 8'h00, 8'h00, 0,0, 8'd0);
    // count = 0: no request, done next cycle.
    row(1, 8'h10, 8'h80, 8'd0, 1, 1,  0,0,0, 8'h00, 8'h00, 0,0, 8'd0);
    row(0, 8'h10, 8'h80, 8'd0, 1, 1,  0,0,0, 8'h00, 8'h00, 1,0, 8'd0);
    row(0, 8'h10, 8'h80, 8'd0, 1, 1,  0,0,0, 8'h00, 8'h00, 0,0, 8'd0);
    // Grant lost while word 0 write would complete; write resumes without re-read.
    row(1, 8'h10, 8'h80, 8'd2, 1, 1,  0,0,0, 8'h00, 8'h00, 0,0, 8'd0);
    row(0, 8'h10, 8'h80, 8'd2, 1, 1,  1,0,0, 8'h00, 8'h00, 0,1, 8'd2);
    row(0, 8'h10, 8'h80, 8'd2, 1, 1,  1,1,0, 8'h10, 8'h00, 0,1, 8'd2);
    row(0, 8'h10, 8'h80, 8'd2, 0, 1,  1,0,0, 8'h80, 8'hA1, 0,1, 8'd2);
    row(0, 8'h10, 8'h80, 8'd2, 0, 1,  1,0,0, 8'h00, 8'h00, 0,1, 8'd2);
    row(0, 8'h10, 8'h80, 8'd2, 1, 1,  1,0,0, 8'h00, 8'h00, 0,1, 8'd2);
    row(0, 8'h10, 8'h80, 8'd2, 1, 1,  1,0,1, 8'h80, 8'hA1, 0,1, 8'd2);
    row(0, 8'h10, 8'h80, 8'd2, 1, 1,  1,1,0, 8'h11, 8'h00, 0,1, 8'd1);
    row(0, 8'h10, 8'h80, 8'd2, 1, 1,  1,0,1, 8'h81, 8'hB2, 0,1, 8'd1);
    row(0, 8'h10, 8'h80, 8'd2, 1, 1,  0,0,0, 8'h00, 8'h00, 1,0, 8'd0);
    row(0, 8'h10, 8'h80, 8'd2, 1, 1,  0,0,0, 8'h00, 8'h00, 0,0, 8'd0);
    // Address wrap: reads FF,00,01; writes FE,FF,00.
    row(1, 8'hFF, 8'hFE, 8'd3, 1, 1,  0,0,0, 8'h00, 8'h00, 0,0, 8'd0);
    row(0, 8'hFF, 8'hFE, 8'd3, 1, 1,  1,0,0, 8'h00, 8'h00, 0,1, 8'd3);
    row(0, 8'hFF, 8'hFE, 8'd3, 1, 1,  1,1,0, 8'hFF, 8'h00, 0,1, 8'd3);
    row(0, 8'hFF, 8'hFE, 8'd3, 1, 1,  1,0,1, 8'hFE, 8'h5A, 0,1, 8'd3);
    row(0, 8'hFF, 8'hFE, 8'd3, 1, 1,  1,1,0, 8'h00, 8'h00, 0,1, 8'd2);
    row(0, 8'hFF, 8'hFE, 8'd3, 1, 1,  1,0,1, 8'hFF, 8'h6B, 0,1, 8'd2);
    row(0, 8'hFF, 8'hFE, 8'd3, 1, 1,  1,1,0, 8'h01, 8'h00, 0,1, 8'd1);
    row(0, 8'hFF, 8'hFE, 8'd3, 1, 1,  1,0,1, 8'h00, 8'h7C, 0,1, 8'd1);
    row(0, 8'hFF, 8'hFE, 8'd3, 1, 1,  0,0,0, 8'h00, 8'h00, 1,0, 8'd0);
    row(0, 8'hFF, 8'hFE, 8'd3, 1, 1,  0,0,0, 8'h00, 8'h00, 0,0, 8'd0);
    // Wait states in RD; start pulses while busy are ignored.
    row(1, 8'h12, 8'h90, 8'd1, 1, 0,  0,0,0, 8'h00, 8'h00, 0,0, 8'd0);
    row(1, 8'h40, 8'h50, 8'd5, 1, 0,  1,0,0, 8'h00, 8'h00, 0,1, 8'd1);
    row(1, 8'h40, 8'h50, 8'd5, 1, 0,  1,1,0, 8'h12, 8'h00, 0,1, 8'd1);
    row(0, 8'h40, 8'h50, 8'd5, 1, 0,  1,1,0, 8'h12, 8'h00, 0,1, 8'd1);
    row(1, 8'h40, 8'h50, 8'd5, 1, 0,  1,1,0, 8'h12, 8'h00, 0,1, 8'd1);
    row(0, 8'h40, 8'h50, 8'd5, 1, 1,  1,1,0, 8'h12, 8'h00, 0,1, 8'd1);
    row(1, 8'h40, 8'h50, 8'd5, 1, 1,  1,0,1, 8'h90, 8'hC3, 0,1, 8'd1);
    row(1, 8'h40, 8'h50, 8'd0, 1, 1,  0,0,0, 8'h00, 8'h00, 1,0, 8'd0);
    row(0, 8'h40, 8'h50, 8'd0, 1, 1,  0,0,0, 8'h00, 8'h00, 0,0, 8'd0);

    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; count = '0;
    bus_grant = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_state", 64'(actual()), 64'(exp_t'(0)));
    @(posedge clk); #1;

    foreach (vq[i]) begin
      start = vq[i].st; src_addr = vq[i].src; dst_addr = vq[i].dst;
      count = vq[i].cnt; bus_grant = vq[i].g; mem_ready = vq[i].r;
      @(negedge clk);
      check($sformatf("vec%0d", i), 64'(actual()), 64'(vq[i].exp));
      @(posedge clk); #1;
    end
    check("wrap_dst_ff", 64'(mem[8'hFF]), 64'h6B);
    check("wrap_dst_00", 64'(mem[8'h00]), 64'h7C);
    check("retry_dst_80", 64'(mem[8'h80]), 64'hA1);

    // Asynchronous reset in the middle of RD of word 1 of 4.
    start = 1'b1; src_addr = 8'h10; dst_addr = 8'hA0; count = 8'd4;
    bus_grant = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_rd_addr", 64'({mem_rd, mem_addr}), 64'({1'b1, 8'h11}));
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", 64'(actual()), 64'(exp_t'(0)));
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("post_reset_idle", 64'(actual()), 64'(exp_t'(0)));
    @(posedge clk); #1;
    start = 1'b1; src_addr = 8'h10; dst_addr = 8'hB0; count = 8'd1;
    @(posedge clk); #1 start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check("restart_done_seen", 64'(seen), 64'd1);
      check("restart_done_state", 64'({busy, bus_req, remaining}), 64'({1'b0, 1'b0, 8'd0}));
      check("restart_dst_b0", 64'(mem[8'hB0]), 64'hA1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
